// File: rtl/rtc_pkg.sv
// Shared BCD types, field limits and helpers for the BCD time-of-day keeper.
package rtc_pkg;

  typedef logic [3:0] bcd_nibble_t;
  typedef logic [7:0] bcd_byte_t;

  localparam bcd_byte_t MAX_SEC_MIN = 8'h59;
  localparam bcd_byte_t MAX_HOUR    = 8'h23;

  // A packed-BCD byte is usable when both digits are decimal and it does not exceed the field limit.
  function automatic logic bcd_valid(input bcd_byte_t v, input bcd_byte_t maxVal);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= maxVal);
  endfunction

  function automatic bcd_byte_t bcd_inc(input bcd_byte_t v);
    bcd_byte_t r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps to 00 after {MOD_TENS, MOD_UNITS}.
// Units always roll at 9 below the top value, so MOD 2/3 gives a 00..23 hour counter.
module bcd_mod_counter
  import rtc_pkg::*;
#(
  parameter bcd_nibble_t MOD_TENS  = 4'd5,
  parameter bcd_nibble_t MOD_UNITS = 4'd9,
  parameter bcd_byte_t   RST_VAL   = 8'h00
) (
  input  logic      inClk,
  input  logic      inRstN,
  input  logic      inc,
  input  logic      load,
  input  bcd_byte_t ldVal,
  output bcd_byte_t val,
  output logic      carry
);

  // Carry is combinational so the next field advances in the same cycle.
  assign carry = inc && (val == {MOD_TENS, MOD_UNITS});

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      val <= RST_VAL;
    end else if (load) begin
      val <= ldVal;
    end else if (inc) begin
      if (carry) val <= 8'h00;
      else       val <= bcd_inc(val);
    end
  end

endmodule

// File: rtl/rtc_bcd_timekeeper.sv
// 24-hour packed-BCD time of day advanced by rising edges of an asynchronous 1 Hz input.
// Optional alarm comparator is built when RTC_ALARM_EN is defined.
module rtc_bcd_timekeeper
  import rtc_pkg::*;
#(
  parameter int        SYNC_STAGES = 2,
  parameter bcd_byte_t RESET_HOUR  = 8'h00,
  parameter bcd_byte_t RESET_MIN   = 8'h00
) (
  input  logic      inClk,
  input  logic      inRstN,
  input  logic      secClk,
  input  logic      holdEn,
  input  logic      loadEn,
  input  bcd_byte_t loadHour,
  input  bcd_byte_t loadMin,
  input  bcd_byte_t loadSec,
  output bcd_byte_t hourBcd,
  output bcd_byte_t minBcd,
  output bcd_byte_t secBcd,
  output logic      secTick,
  output logic      dayWrap,
  output logic      loadErr
`ifdef RTC_ALARM_EN
  ,
  input  bcd_byte_t alarmHour,
  input  bcd_byte_t alarmMin,
  input  logic      alarmArm,
  input  logic      alarmClr,
  output logic      alarmOut
`endif
);

  localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   syncPrev;
  logic [2:0]             armCnt;
  logic                   armed;
  logic                   tick;
  logic                   countEn;
  logic                   loadOk;
  logic                   doLoad;
  logic                   secCarry;
  logic                   minCarry;
  logic                   hourCarry;

  // Ticks stay blocked until the sync chain and edge register hold post-reset samples,
  // so a secClk already high at release is never mistaken for a rising edge.
  assign armed = (armCnt == ARM_CYCLES);

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      sync     <= '0;
      syncPrev <= 1'b0;
      armCnt   <= 3'd0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], secClk};
      syncPrev <= sync[SYNC_STAGES-1];
      if (!armed) armCnt <= armCnt + 3'd1;
    end
  end

  assign tick    = sync[SYNC_STAGES-1] & ~syncPrev & armed;
  // A load swallows any coincident tick; hold drops ticks without backlog.
  assign countEn = tick & ~loadEn & ~holdEn;
  assign loadOk  = bcd_valid(loadHour, MAX_HOUR) & bcd_valid(loadMin, MAX_SEC_MIN)
                 & bcd_valid(loadSec, MAX_SEC_MIN);
  assign doLoad  = loadEn & loadOk;

  bcd_mod_counter #(.MOD_TENS(4'd5), .MOD_UNITS(4'd9), .RST_VAL(8'h00)) uSec (
    .inClk(inClk), .inRstN(inRstN), .inc(countEn), .load(doLoad),
    .ldVal(loadSec), .val(secBcd), .carry(secCarry)
  );

  bcd_mod_counter #(.MOD_TENS(4'd5), .MOD_UNITS(4'd9), .RST_VAL(RESET_MIN)) uMin (
    .inClk(inClk), .inRstN(inRstN), .inc(secCarry), .load(doLoad),
    .ldVal(loadMin), .val(minBcd), .carry(minCarry)
  );

  bcd_mod_counter #(.MOD_TENS(4'd2), .MOD_UNITS(4'd3), .RST_VAL(RESET_HOUR)) uHour (
    .inClk(inClk), .inRstN(inRstN), .inc(minCarry), .load(doLoad),
    .ldVal(loadHour), .val(hourBcd), .carry(hourCarry)
  );

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      secTick <= 1'b0;
      dayWrap <= 1'b0;
      loadErr <= 1'b0;
    end else begin
      secTick <= countEn;
      dayWrap <= hourCarry;
      loadErr <= loadEn & ~loadOk;
    end
  end

`ifdef RTC_ALARM_EN
  bcd_byte_t nextMin;
  bcd_byte_t nextHour;
  logic      alarmHit;

  // Only a counted second rolling into :00 can match; loads never reach secCarry.
  always_comb begin
    nextMin  = minBcd;
    nextHour = hourBcd;
    if (minCarry)      nextMin = 8'h00;
    else if (secCarry) nextMin = bcd_inc(minBcd);
    if (hourCarry)     nextHour = 8'h00;
    else if (minCarry) nextHour = bcd_inc(hourBcd);
  end

  assign alarmHit = alarmArm & secCarry & (nextHour == alarmHour) & (nextMin == alarmMin);

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      alarmOut <= 1'b0;
    end else if (alarmClr || !alarmArm) begin
      alarmOut <= 1'b0;
    end else if (alarmHit) begin
      alarmOut <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// Directed self-checking bench for rtc_bcd_timekeeper (default parameters, SYNC_STAGES=2).
module tb_rtc_bcd_timekeeper;

  logic       inClk;
  logic       inRstN;
  logic       secClk;
  logic       holdEn;
  logic       loadEn;
  logic [7:0] loadHour;
  logic [7:0] loadMin;
  logic [7:0] loadSec;
  logic [7:0] hourBcd;
  logic [7:0] minBcd;
  logic [7:0] secBcd;
  logic       secTick;
  logic       dayWrap;
  logic       loadErr;
`ifdef RTC_ALARM_EN
  logic [7:0] alarmHour;
  logic [7:0] alarmMin;
  logic       alarmArm;
  logic       alarmClr;
  logic       alarmOut;
`endif

  int checks = 0;
  int errors = 0;

  rtc_bcd_timekeeper dut (
    .inClk(inClk), .inRstN(inRstN), .secClk(secClk), .holdEn(holdEn), .loadEn(loadEn),
    .loadHour(loadHour), .loadMin(loadMin), .loadSec(loadSec),
    .hourBcd(hourBcd), .minBcd(minBcd), .secBcd(secBcd),
    .secTick(secTick), .dayWrap(dayWrap), .loadErr(loadErr)
`ifdef RTC_ALARM_EN
    ,
    .alarmHour(alarmHour), .alarmMin(alarmMin), .alarmArm(alarmArm),
    .alarmClr(alarmClr), .alarmOut(alarmOut)
`endif
  );

  // Clock and reset block
  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  // Driver tasks: inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge inClk);
    #1;
  endtask

  task automatic apply_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    loadHour = h; loadMin = m; loadSec = s; loadEn = 1'b1;
    step();
    loadEn = 1'b0;
  endtask

  // Raises secClk; on return the counted second has just been registered.
  task automatic sec_rise_to_tick();
    secClk = 1'b1;
    repeat (3) step();
  endtask

  task automatic sec_fall();
    secClk = 1'b0;
    repeat (3) step();
  endtask

  function automatic logic [26:0] observed();
    return {hourBcd, minBcd, secBcd, secTick, dayWrap, loadErr};
  endfunction

  task automatic test_reset();
    logic [26:0] obs;
    inRstN = 1'b0; secClk = 1'b1; holdEn = 1'b0; loadEn = 1'b0;
    loadHour = 8'h00; loadMin = 8'h00; loadSec = 8'h00;
    repeat (3) step();
    obs = observed();
    checks++;
    if (obs !== 27'h0) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs, 27'h0);
    end
    inRstN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      obs = observed();
      checks++;
      if (obs !== 27'h0) begin
        errors++;
        $display("FAIL no_tick_after_release cycle %0d: got %h expected %h", i, obs, 27'h0);
      end
    end
    sec_fall();
  endtask

  task automatic test_latency();
    logic [26:0] obs;
    logic [26:0] expv [4];
    expv[0] = {24'h000000, 3'b000};
    expv[1] = {24'h000000, 3'b000};
    expv[2] = {24'h000001, 3'b100};
    expv[3] = {24'h000001, 3'b000};
    secClk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      obs = observed();
      checks++;
      if (obs !== expv[i]) begin
        errors++;
        $display("FAIL latency edge k+%0d: got %h expected %h", i, obs, expv[i]);
      end
    end
    sec_fall();
  endtask

  task automatic test_day_wrap();
    logic [26:0] obs;
    apply_load(8'h23, 8'h59, 8'h58);
    obs = observed();
    checks++;
    if (obs !== {24'h235958, 3'b000}) begin
      errors++;
      $display("FAIL load_235958: got %h expected %h", obs, {24'h235958, 3'b000});
    end
    sec_rise_to_tick();
    obs = observed();
    checks++;
    if (obs !== {24'h235959, 3'b100}) begin
      errors++;
      $display("FAIL tick_235959: got %h expected %h", obs, {24'h235959, 3'b100});
    end
    sec_fall();
    sec_rise_to_tick();
    obs = observed();
    checks++;
    if (obs !== {24'h000000, 3'b110}) begin
      errors++;
      $display("FAIL day_wrap: got %h expected %h", obs, {24'h000000, 3'b110});
    end
    step();
    obs = observed();
    checks++;
    if (obs !== {24'h000000, 3'b000}) begin
      errors++;
      $display("FAIL day_wrap_one_cycle: got %h expected %h", obs, {24'h000000, 3'b000});
    end
    sec_fall();
  endtask

  task automatic test_carry();
    logic [23:0] startv [3];
    logic [23:0] endv   [3];
    logic [26:0] obs;
    startv[0] = 24'h095959; endv[0] = 24'h100000;
    startv[1] = 24'h195959; endv[1] = 24'h200000;
    startv[2] = 24'h004509; endv[2] = 24'h004510;
    for (int i = 0; i < 3; i++) begin
      apply_load(startv[i][23:16], startv[i][15:8], startv[i][7:0]);
      sec_rise_to_tick();
      obs = observed();
      checks++;
      if (obs !== {endv[i], 3'b100}) begin
        errors++;
        $display("FAIL carry from %h: got %h expected %h", startv[i], obs, {endv[i], 3'b100});
      end
      sec_fall();
    end
  endtask

  task automatic test_load_err();
    logic [23:0] bad [4];
    logic [26:0] obs;
    bad[0] = 24'h126000;
    bad[1] = 24'h240000;
    bad[2] = 24'h12005a;
    bad[3] = 24'h1a0000;
    apply_load(8'h20, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      apply_load(bad[i][23:16], bad[i][15:8], bad[i][7:0]);
      obs = observed();
      checks++;
      if (obs !== {24'h200000, 3'b001}) begin
        errors++;
        $display("FAIL reject %h: got %h expected %h", bad[i], obs, {24'h200000, 3'b001});
      end
      step();
      obs = observed();
      checks++;
      if (obs !== {24'h200000, 3'b000}) begin
        errors++;
        $display("FAIL reject_one_cycle %h: got %h expected %h", bad[i], obs, {24'h200000, 3'b000});
      end
    end
  endtask

  task automatic test_load_tick();
    logic [26:0] obs;
    secClk = 1'b1;
    repeat (2) step();
    apply_load(8'h12, 8'h34, 8'h56);
    obs = observed();
    checks++;
    if (obs !== {24'h123456, 3'b000}) begin
      errors++;
      $display("FAIL load_beats_tick: got %h expected %h", obs, {24'h123456, 3'b000});
    end
    step();
    obs = observed();
    checks++;
    if (obs !== {24'h123456, 3'b000}) begin
      errors++;
      $display("FAIL tick_discarded: got %h expected %h", obs, {24'h123456, 3'b000});
    end
    sec_fall();
    secClk = 1'b1;
    repeat (2) step();
    apply_load(8'h12, 8'h60, 8'h00);
    obs = observed();
    checks++;
    if (obs !== {24'h123456, 3'b001}) begin
      errors++;
      $display("FAIL rejected_load_with_tick: got %h expected %h", obs, {24'h123456, 3'b001});
    end
    sec_fall();
  endtask

  task automatic test_hold();
    logic [26:0] obs;
    holdEn = 1'b1;
    for (int p = 0; p < 3; p++) begin
      secClk = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        obs = observed();
        checks++;
        if (obs !== {24'h123456, 3'b000}) begin
          errors++;
          $display("FAIL hold pulse %0d cycle %0d: got %h expected %h", p, i, obs, {24'h123456, 3'b000});
        end
      end
      sec_fall();
    end
    holdEn = 1'b0;
    sec_rise_to_tick();
    obs = observed();
    checks++;
    if (obs !== {24'h123457, 3'b100}) begin
      errors++;
      $display("FAIL resume_after_hold: got %h expected %h", obs, {24'h123457, 3'b100});
    end
    sec_fall();
    holdEn = 1'b1;
    apply_load(8'h07, 8'h08, 8'h09);
    obs = observed();
    checks++;
    if (obs !== {24'h070809, 3'b000}) begin
      errors++;
      $display("FAIL load_during_hold: got %h expected %h", obs, {24'h070809, 3'b000});
    end
    holdEn = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [26:0] obs;
    apply_load(8'h05, 8'h05, 8'h05);
    secClk = 1'b1;
    repeat (2) step();
    #2 inRstN = 1'b0;
    #1;
    obs = observed();
    checks++;
    if (obs !== 27'h0) begin
      errors++;
      $display("FAIL async_reset_mid: got %h expected %h", obs, 27'h0);
    end
    step();
    inRstN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      obs = observed();
      checks++;
      if (obs !== 27'h0) begin
        errors++;
        $display("FAIL lost_tick cycle %0d: got %h expected %h", i, obs, 27'h0);
      end
    end
    sec_fall();
  endtask

`ifdef RTC_ALARM_EN
  task automatic test_alarm();
    alarmHour = 8'h06; alarmMin = 8'h30; alarmArm = 1'b1; alarmClr = 1'b0;
    apply_load(8'h06, 8'h30, 8'h00);
    step();
    checks++;
    if (alarmOut !== 1'b0) begin
      errors++;
      $display("FAIL alarm_not_on_load: got %b expected 0", alarmOut);
    end
    apply_load(8'h06, 8'h29, 8'h59);
    sec_rise_to_tick();
    checks++;
    if ({hourBcd, minBcd, secBcd, alarmOut} !== {24'h063000, 1'b1}) begin
      errors++;
      $display("FAIL alarm_set: got %h expected %h", {hourBcd, minBcd, secBcd, alarmOut}, {24'h063000, 1'b1});
    end
    sec_fall();
    checks++;
    if (alarmOut !== 1'b1) begin
      errors++;
      $display("FAIL alarm_held: got %b expected 1", alarmOut);
    end
    alarmClr = 1'b1;
    step();
    alarmClr = 1'b0;
    checks++;
    if (alarmOut !== 1'b0) begin
      errors++;
      $display("FAIL alarm_clr: got %b expected 0", alarmOut);
    end
  endtask
`endif

  initial begin
`ifdef RTC_ALARM_EN
    alarmHour = 8'h00; alarmMin = 8'h00; alarmArm = 1'b0; alarmClr = 1'b0;
`endif
    test_reset();
    test_latency();
    test_day_wrap();
    test_carry();
    test_load_err();
    test_load_tick();
    test_hold();
    test_reset_mid();
`ifdef RTC_ALARM_EN
    test_alarm();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
